// File: rtl/press_event_queue.sv
// -----------------------------------------------------------------------------
// press_event_queue
//
// Consumer side of the debounced-button handshake. Each detector channel
// holds wasPressed high until it sees its ackPress pulse. This block scans
// the channels with round-robin priority and acknowledges one pending press
// at a time. It pushes the granted channel index into a small show-ahead
// FIFO for downstream logic. While the FIFO is full no acknowledge is
// issued, so each detector keeps its press pending and nothing is lost.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous, active-high
//   wasPressed  per-channel press pending (held by the detector until acked)
//   ackPress    per-channel acknowledge, one-hot single-cycle pulse
//   eventValid  FIFO holds at least one event
//   eventId     channel index at the FIFO head (show-ahead)
//   eventAck    downstream pop; ignored while eventValid is low
//   fifoCount   number of events held, 0..FIFO_DEPTH
//   fifoFull    fifoCount == FIFO_DEPTH
// -----------------------------------------------------------------------------
module press_event_queue #(
   parameter int CHANNELS   = 4,
   parameter int ID_WIDTH   = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_WIDTH  = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   wasPressed,
   output logic [CHANNELS-1:0]   ackPress,
   output logic                  eventValid,
   output logic [ID_WIDTH-1:0]   eventId,
   input  logic                  eventAck,
   output logic [PTR_WIDTH:0]    fifoCount,
   output logic                  fifoFull
);

   typedef enum logic {
      SCAN = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t                state;
   logic [ID_WIDTH-1:0]   rr_last;

   logic                  grant_valid;
   logic [ID_WIDTH-1:0]   grant_id;
   logic [CHANNELS-1:0]   grant_onehot;
   int                    best_dist;

   logic [ID_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic                  push;
   logic                  pop;

   // Distance of channel ch from the slot just after last, walking upward and
   // wrapping at CHANNELS. The channel right after the last grant scores 0.
   function automatic int rr_distance(input int ch, input int last);
      return (ch - last - 1 + 2 * CHANNELS) % CHANNELS;
   endfunction

   // Round-robin arbiter: the pending channel closest (upward, wrapping) to
   // the last grant wins.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      grant_valid  = 1'b0;
      grant_id     = '0;
      grant_onehot = '0;
      best_dist    = CHANNELS;
      for (int i = 0; i < CHANNELS; i++) begin
         if (wasPressed[i] && (rr_distance(i, int'(rr_last)) < best_dist)) begin
            best_dist       = rr_distance(i, int'(rr_last));
            grant_valid     = 1'b1;
            grant_id        = ID_WIDTH'(i);
            grant_onehot    = '0;
            grant_onehot[i] = 1'b1;
         end
      end
   end

   // Fullness uses the registered count only; a pop on the same edge does
   // not free a slot for this grant.
   assign push = (state == SCAN) && grant_valid && !fifoFull;
   assign pop  = eventAck && eventValid;

   // Handshake FSM. ackPress is registered, so it is high for exactly the
   // ACK cycle. wasPressed of the granted channel is still high during
   // that cycle, so no grant is evaluated there.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state    <= SCAN;
         ackPress <= '0;
         rr_last  <= ID_WIDTH'(CHANNELS - 1);
      end else begin
         case (state)
            SCAN: begin
               if (push) begin
                  ackPress <= grant_onehot;
                  rr_last  <= grant_id;
                  state    <= ACK;
               end else begin
                  ackPress <= '0;
               end
            end
            ACK: begin
               ackPress <= '0;
               state    <= SCAN;
            end
            default: begin
               ackPress <= '0;
               state    <= SCAN;
            end
         endcase
      end
   end

   // Circular event buffer. FIFO_DEPTH is a power of two, so the pointers
   // wrap by plain overflow.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fifoCount <= '0;
         // NOTE: the storage is only FIFO_DEPTH x ID_WIDTH bits, so it is
         // cleared on reset to make eventId read 0 out of reset. A push that
         // coincides with reset is discarded by the same clear.
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= grant_id;
            wr_ptr      <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         end
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + (PTR_WIDTH + 1)'(1);
            2'b01:   fifoCount <= fifoCount - (PTR_WIDTH + 1)'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   assign eventValid = (fifoCount != '0);
   assign fifoFull   = (fifoCount == (PTR_WIDTH + 1)'(FIFO_DEPTH));
   assign eventId    = mem[rd_ptr];

endmodule

// File: tb/tb_press_event_queue.sv
// -----------------------------------------------------------------------------
// tb_press_event_queue
//
// Directed bench for press_event_queue. A tiny detector model clears a
// wasPressed bit once it has seen that channel's ackPress. Outputs are sampled
// 1 time unit after each rising edge. Inputs change at the same point.
// -----------------------------------------------------------------------------
module tb_press_event_queue;

   logic       clock;
   logic       reset;
   logic [3:0] wasPressed;
   logic [3:0] ackPress;
   logic       eventValid;
   logic [1:0] eventId;
   logic       eventAck;
   logic [2:0] fifoCount;
   logic       fifoFull;

   logic       auto_clear;
   int         n_checks;
   int         n_fail;

   press_event_queue #(
      .CHANNELS   (4),
      .ID_WIDTH   (2),
      .FIFO_DEPTH (4),
      .PTR_WIDTH  (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .wasPressed (wasPressed),
      .ackPress   (ackPress),
      .eventValid (eventValid),
      .eventId    (eventId),
      .eventAck   (eventAck),
      .fifoCount  (fifoCount),
      .fifoFull   (fifoFull)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock edge. The detector model drops any wasPressed bit whose ack
   // was visible during the cycle that just ended.
   task automatic tick();
      logic [3:0] prev_ack;
      prev_ack = ackPress;
      @(posedge clock);
      #1;
      if (auto_clear) wasPressed = wasPressed & ~prev_ack;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      wasPressed = '0;
      eventAck   = 1'b0;
      auto_clear = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_ack",   32'(ackPress),   32'h0);
      check("rst_valid", 32'(eventValid), 32'h0);
      check("rst_id",    32'(eventId),    32'h0);
      check("rst_count", 32'(fifoCount),  32'h0);
      check("rst_full",  32'(fifoFull),   32'h0);

      // Single press on channel 2
      wasPressed = 4'b0100;
      tick();
      check("single_ack",   32'(ackPress),   32'h4);
      check("single_valid", 32'(eventValid), 32'h1);
      check("single_id",    32'(eventId),    32'h2);
      check("single_count", 32'(fifoCount),  32'h1);
      tick();
      check("single_ack_drop", 32'(ackPress),  32'h0);
      check("single_count2",   32'(fifoCount), 32'h1);
      tick();
      check("single_no_reack", 32'(ackPress), 32'h0);
      eventAck = 1'b1;
      tick();
      eventAck = 1'b0;
      check("single_pop_count", 32'(fifoCount),  32'h0);
      check("single_pop_valid", 32'(eventValid), 32'h0);

      // Simultaneous presses on 0 and 3, twice
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         wasPressed = 4'b1001;
         tick();
         check("simul_first_ack", 32'(ackPress), 32'h1);
         tick();
         check("simul_gap", 32'(ackPress), 32'h0);
         tick();
         check("simul_second_ack", 32'(ackPress), 32'h8);
         check("simul_count", 32'(fifoCount), 32'(2 * rep + 2));
         tick();
         check("simul_idle", 32'(ackPress), 32'h0);
      end
      check("simul_full", 32'(fifoFull), 32'h1);
      eventAck = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("simul_head", 32'(eventId), (k % 2 == 0) ? 32'h0 : 32'h3);
         tick();
         check("simul_drain_count", 32'(fifoCount), 32'(3 - k));
      end
      eventAck = 1'b0;

      // Round-robin with all channels always pending and eventAck high
      do_reset();
      auto_clear = 1'b0;
      wasPressed = 4'b1111;
      eventAck   = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("rr_grant", 32'(ackPress), 32'(1 << (k % 4)));
         check("rr_id",    32'(eventId),  32'(k % 4));
         tick();
         check("rr_gap",   32'(ackPress), 32'h0);
         check("rr_count", 32'(fifoCount), 32'h0);
      end
      eventAck   = 1'b0;
      wasPressed = '0;
      auto_clear = 1'b1;

      // Back-pressure: five presses on channel 1 with no pops
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wasPressed = 4'b0010;
         tick();
         check("bp_ack",   32'(ackPress),  32'h2);
         check("bp_count", 32'(fifoCount), 32'(k + 1));
         tick();
         check("bp_gap", 32'(ackPress), 32'h0);
      end
      check("bp_full", 32'(fifoFull), 32'h1);
      wasPressed = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_held_ack",   32'(ackPress),  32'h0);
         check("bp_held_count", 32'(fifoCount), 32'h4);
      end
      eventAck = 1'b1;
      tick();
      eventAck = 1'b0;
      check("bp_pop_no_ack", 32'(ackPress),  32'h0);
      check("bp_pop_count",  32'(fifoCount), 32'h3);
      check("bp_pop_full",   32'(fifoFull),  32'h0);
      tick();
      check("bp_resume_ack",   32'(ackPress),  32'h2);
      check("bp_resume_count", 32'(fifoCount), 32'h4);
      check("bp_resume_full",  32'(fifoFull),  32'h1);
      tick();
      check("bp_resume_gap", 32'(ackPress), 32'h0);

      // Push and pop on the same edge at count 2, then pop on empty
      do_reset();
      wasPressed = 4'b0001;
      tick();
      tick();
      wasPressed = 4'b0100;
      tick();
      tick();
      check("pp_pre_count", 32'(fifoCount), 32'h2);
      check("pp_pre_head",  32'(eventId),   32'h0);
      wasPressed = 4'b1000;
      eventAck   = 1'b1;
      tick();
      eventAck   = 1'b0;
      check("pp_ack",   32'(ackPress),  32'h8);
      check("pp_count", 32'(fifoCount), 32'h2);
      check("pp_head",  32'(eventId),   32'h2);
      tick();
      eventAck = 1'b1;
      tick();
      check("pp_drain1_head",  32'(eventId),   32'h3);
      check("pp_drain1_count", 32'(fifoCount), 32'h1);
      tick();
      check("pp_drain2_count", 32'(fifoCount),  32'h0);
      check("pp_drain2_valid", 32'(eventValid), 32'h0);
      tick();
      tick();
      eventAck = 1'b0;
      check("empty_pop_count", 32'(fifoCount),  32'h0);
      check("empty_pop_valid", 32'(eventValid), 32'h0);
      wasPressed = 4'b0001;
      tick();
      check("empty_pop_after_ack",   32'(ackPress),  32'h1);
      check("empty_pop_after_count", 32'(fifoCount), 32'h1);
      check("empty_pop_after_head",  32'(eventId),   32'h0);
      tick();

      // Reset asserted during the ACK cycle
      do_reset();
      auto_clear = 1'b0;
      wasPressed = 4'b1000;
      tick();
      check("rack_grant", 32'(ackPress), 32'h8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rack_ack",   32'(ackPress),   32'h0);
      check("rack_count", 32'(fifoCount),  32'h0);
      check("rack_valid", 32'(eventValid), 32'h0);
      tick();
      check("rack_regrant",       32'(ackPress),  32'h8);
      check("rack_regrant_count", 32'(fifoCount), 32'h1);
      check("rack_regrant_id",    32'(eventId),   32'h3);
      tick();
      check("rack_regrant_gap", 32'(ackPress), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
